// File: rtl/bcast_tx_pkg.sv
// Shared broadcast word layout {en,start,last,unit_id,data} and the transmitter FSM states.
// Unit-side decoders use the same offset helpers so both ends agree on the format.
package bcast_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int BC_CTRL_W = 3;

  function automatic int bc_width(input int unit_w, input int data_w);
    return BC_CTRL_W + unit_w + data_w;
  endfunction

  function automatic int bc_uid_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int bc_last_bit(input int unit_w, input int data_w);
    return data_w + unit_w;
  endfunction

  function automatic int bc_start_bit(input int unit_w, input int data_w);
    return data_w + unit_w + 1;
  endfunction

  function automatic int bc_en_bit(input int unit_w, input int data_w);
    return data_w + unit_w + 2;
  endfunction

endpackage

// File: rtl/bcast_tx_prio.sv
// Lowest-index-first priority encoder: one-hot/multi-hot request to index plus any-valid.
module prio_enc_lsb #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  always_comb begin
    idx_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[k]) idx_o = W'(k);
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/bcast_tx.sv
// Host-side packet transmitter: picks the lowest idle, non-pending unit per packet and
// streams the packet words into the broadcast network one cycle after acceptance.
module bcast_tx
  import bcast_tx_pkg::*;
#(
  parameter int  DATA_WIDTH  = 16,
  parameter int  N_UNITS     = 8,
  parameter int  MAX_WORDS   = 8,
  localparam int UNIT_W      = $clog2(N_UNITS),
  localparam int BCAST_WIDTH = bc_width(UNIT_W, DATA_WIDTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [DATA_WIDTH-1:0]  in_data_i,
  input  logic                   in_start_i,
  input  logic                   in_last_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [N_UNITS-1:0]     unit_idle_i,
  output logic [BCAST_WIDTH-1:0] bcast_out_o,
  output logic                   err_o
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);
  localparam bit ONE_WORD = (MAX_WORDS == 1);
  localparam int UID_LSB   = bc_uid_lsb(DATA_WIDTH);
  localparam int LAST_BIT  = bc_last_bit(UNIT_W, DATA_WIDTH);
  localparam int START_BIT = bc_start_bit(UNIT_W, DATA_WIDTH);
  localparam int EN_BIT    = bc_en_bit(UNIT_W, DATA_WIDTH);

  state_e                 state_q;
  logic [UNIT_W-1:0]      uid_q;
  logic [UNIT_W-1:0]      sel_idx;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_inc;
  logic [N_UNITS-1:0]     pend_q;
  logic [N_UNITS-1:0]     idle_q;
  logic [N_UNITS-1:0]     elig;
  logic [N_UNITS-1:0]     pend_set;
  logic [BCAST_WIDTH-1:0] bcast_q;
  logic                   run_q;
  logic                   err_q;
  logic                   any_elig;
  logic                   acc;
  logic                   first_acc;

  function automatic logic [BCAST_WIDTH-1:0] pack(input logic st, input logic ls,
                                                   input logic [UNIT_W-1:0] uid,
                                                   input logic [DATA_WIDTH-1:0] d);
    logic [BCAST_WIDTH-1:0] p;
    p = '0;
    p[DATA_WIDTH-1:0]       = d;
    p[UID_LSB +: UNIT_W]    = uid;
    p[LAST_BIT]             = ls;
    p[START_BIT]            = st;
    p[EN_BIT]               = 1'b1;
    return p;
  endfunction

  // Idle status is registered, so a unit becoming idle is usable from the following cycle.
  assign elig = idle_q & ~pend_q;

  prio_enc_lsb #(
    .N(N_UNITS),
    .W(UNIT_W)
  ) u_prio (
    .req_i(elig),
    .idx_o(sel_idx),
    .any_o(any_elig)
  );

  assign in_ready_o = run_q & ((state_q != ST_IDLE) | ~(in_valid_i & in_start_i) | any_elig);
  assign acc        = in_valid_i & in_ready_o;
  assign first_acc  = acc & in_start_i & (state_q == ST_IDLE);
  assign cnt_inc    = cnt_q + ONE_CNT;

  always_comb begin
    pend_set = '0;
    if (first_acc) pend_set[sel_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      uid_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
      idle_q  <= '0;
      bcast_q <= '0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      idle_q  <= unit_idle_i;
      pend_q  <= (pend_q & unit_idle_i) | pend_set;
      bcast_q <= '0;
      if (acc) begin
        case (state_q)
          ST_IDLE: begin
            if (in_start_i) begin
              uid_q   <= sel_idx;
              cnt_q   <= ONE_CNT;
              bcast_q <= pack(1'b1, in_last_i | ONE_WORD, sel_idx, in_data_i);
              if (!in_last_i) begin
                if (ONE_WORD) begin
                  err_q   <= 1'b1;
                  state_q <= ST_DRAIN;
                end else begin
                  state_q <= ST_SEND;
                end
              end
            end else begin
              err_q <= 1'b1;
            end
          end
          ST_SEND: begin
            cnt_q <= cnt_inc;
            if (in_start_i) begin
              bcast_q <= pack(1'b0, 1'b1, uid_q, in_data_i);
              err_q   <= 1'b1;
              state_q <= ST_IDLE;
            end else if (in_last_i) begin
              bcast_q <= pack(1'b0, 1'b1, uid_q, in_data_i);
              state_q <= ST_IDLE;
            end else if (cnt_inc == MAX_CNT) begin
              bcast_q <= pack(1'b0, 1'b1, uid_q, in_data_i);
              err_q   <= 1'b1;
              state_q <= ST_DRAIN;
            end else begin
              bcast_q <= pack(1'b0, 1'b0, uid_q, in_data_i);
            end
          end
          ST_DRAIN: begin
            if (in_last_i) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bcast_out_o = bcast_q;
  assign err_o       = err_q;

endmodule

// File: doc/bcast_tx.md
BCAST_TX -- requirements
Module: bcast_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning the payload width per broadcast word.
REQ-002 SHALL have parameter N_UNITS, default 8, meaning the number of destination units; legal range 2..256.
REQ-003 SHALL have parameter MAX_WORDS, default 8, meaning the maximum number of words per packet; legal range 1..256.
REQ-004 SHALL have derived localparam UNIT_W = clog2(N_UNITS) and BCAST_WIDTH = 3+UNIT_W+DATA_WIDTH.
REQ-005 CLK  input  1  the single clock; all logic is on its rising edge.
REQ-006 RST_N  input  1  reset, asynchronous and active-low.
REQ-007 in_data  input  DATA_WIDTH  packet word from the host side.
REQ-008 in_start  input  1  marks the first word of a packet.
REQ-009 in_last  input  1  marks the last word of a packet.
REQ-010 in_valid  input  1  in_data, in_start and in_last are valid.
REQ-011 in_ready  output  1  word accepted when in_valid and in_ready are both high.
REQ-012 unit_idle  input  N_UNITS  per-unit idle status, delayed by an arbitrary number of cycles.
REQ-013 bcast_out  output  BCAST_WIDTH  {en,start,last,unit_id[UNIT_W],data}; drives the entry of the broadcast network.
REQ-014 err  output  1  sticky protocol-error flag.

Function
REQ-015 SHALL implement FSM states IDLE, SEND and DRAIN.
REQ-016 Unit k SHALL be eligible iff unit_idle[k]=1 and pending[k]=0.
REQ-017 In IDLE, in_ready SHALL be 0 while in_valid&in_start=1 and no unit is eligible; the word SHALL be held, not dropped.
REQ-018 In IDLE, with in_valid&in_start=1 and at least one unit eligible, the word SHALL be accepted, the lowest-index eligible unit latched as unit_id, and the FSM SHALL go to SEND (or stay IDLE if in_last=1).
REQ-019 In IDLE, a valid word with in_start=0 SHALL be accepted (in_ready=1), discarded, and SHALL set err.
REQ-020 In SEND, in_ready SHALL be 1.
REQ-021 Each accepted word SHALL appear on bcast_out exactly one cycle later, with en=1, start equal to the in_start of the first word only, and unit_id equal to the latched unit.
REQ-022 On a cycle with no accepted word, bcast_out SHALL be all-zero (en=0).
REQ-023 A word counter SHALL count the words of the current packet, 1 for the first word.
REQ-024 When the accepted word has in_last=1, last=1 SHALL be emitted and the FSM SHALL go to IDLE.
REQ-025 When the counter reaches MAX_WORDS with in_last=0, that word SHALL be emitted with last=1, err SHALL be set, and the FSM SHALL go to DRAIN.
REQ-026 In SEND, an accepted word with in_start=1 SHALL terminate the open packet: emit that word with last=1, set err, and go to IDLE; the word SHALL not start a new packet.
REQ-027 In DRAIN, in_ready SHALL be 1 and words SHALL be discarded until one with in_last=1 is accepted, then the FSM SHALL go to IDLE.
REQ-028 pending[unit_id] SHALL be set on the cycle the packet's first word is accepted.
REQ-029 pending[k] SHALL clear on a cycle where unit_idle[k]=0.
REQ-030 If set and clear of pending[k] occur in the same cycle, set SHALL win.
REQ-031 err SHALL stay high until reset.

Reset
REQ-032 RST_N low SHALL asynchronously force the FSM to IDLE, bcast_out=0, in_ready=0, pending=0, the word counter to 0 and err=0.
REQ-033 Reset asserted mid-packet SHALL abandon the packet; no trailing last word SHALL be emitted.

Structure
REQ-034 The bcast_out field offsets and widths SHALL be defined in a shared bcast package used by this block and by unit-side decoders.
REQ-035 The lowest-index eligible selection SHALL be a sub-module named prio_enc_lsb (N_UNITS-bit one-hot to index plus any-valid output).
REQ-036 bcast_out SHALL be registered, with no combinational path from in_* or unit_idle to bcast_out.

Verification (N_UNITS=4, DATA_WIDTH=16, MAX_WORDS=4)
REQ-037 unit_idle=4'b1111; packet 0xA1(start),0xA2,0xA3(last) -> bcast_out en=1, unit_id=0, words one cycle after acceptance, start on 0xA1, last on 0xA3; pending=4'b0001.
REQ-038 Then a second packet with unit_idle=4'b1111 held -> unit_id=1; a third packet -> unit_id=2.
REQ-039 unit_idle=4'b0000 with a start word valid -> in_ready=0 and bcast_out en=0; drive unit_idle[3]=1 -> accepted next cycle with unit_id=3.
REQ-040 Six-word packet with last on word 6 -> word 4 emitted with last=1, err=1, words 5-6 dropped, FSM back in IDLE after word 6.
REQ-041 Non-start word 0x55 in IDLE -> dropped, err=1, no en on bcast_out.
REQ-042 RST_N low after word 2 of 3 -> bcast_out=0, pending=0, err=0 immediately; the next start word goes to unit 0.
